// File: rtl/lv1_bus_pkg.sv
// Shared definitions for the L1 bus-side initiator.
// Holds the MESI state encodings and the initiator FSM state type,
// plus small state-class helpers used by the top level.
package lv1_bus_pkg;

  localparam int unsigned INVALID   = 0;
  localparam int unsigned SHARED    = 1;
  localparam int unsigned EXCLUSIVE = 2;
  localparam int unsigned MODIFIED  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    WB,
    FILL,
    INV,
    UPD
  } state_e;

  // States in which the initiator owns or is requesting the bus.
  function automatic logic is_bus_state(input state_e s);
    return (s == ARB) || (s == WB) || (s == FILL) || (s == INV);
  endfunction

  // States that wait on bus_done and are guarded by the timeout.
  function automatic logic is_wait_state(input state_e s);
    return (s == WB) || (s == FILL) || (s == INV);
  endfunction

endpackage

// File: rtl/bus_tmo_cnt.sv
// Timeout counter for the bus initiator's waiting states.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr_i      - clear the count to zero (state entry)
//   en_i       - count one waiting cycle
//   expire_o   - count has reached TIMEOUT-1
module bus_tmo_cnt #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TMO_WID = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TMO_WID-1:0] cnt_q;

  assign expire_o = (cnt_q == TMO_WID'(TIMEOUT - 1));

  // Saturates at the expire value so a stalled count never wraps.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bus_req_init_lv1_md.sv
// L1 bus-side initiator: classifies processor accesses, arbitrates for the
// shared bus, issues writeback / fill / invalidate transactions and then
// commands the MESI update of the accessed block.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cpu_rd, cpu_wr, cpu_addr - processor request (rd+wr together = write)
//   hit, blk_mesi            - tag lookup result for the accessed block
//   victim_mesi, victim_addr - victim way state/address on a miss
//   bus_req / bus_gnt        - arbiter handshake
//   bus_rd, bus_rdx, invalidate, bus_wb, bus_addr - bus command and address
//   bus_done, shared         - transaction completion and shared snoop
//   mesi_upd, new_mesi       - one-cycle MESI write strobe and value
//   cpu_done, busy, bus_err  - completion pulse, activity, timeout pulse
module bus_req_init_lv1_md
  import lv1_bus_pkg::*;
#(
  parameter int unsigned ADDR_WID = 32,
  parameter int unsigned MESI_WID = 2,
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned TMO_WID  = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_WID-1:0] cpu_addr,
  input  logic                hit,
  input  logic [MESI_WID-1:0] blk_mesi,
  input  logic [MESI_WID-1:0] victim_mesi,
  input  logic [ADDR_WID-1:0] victim_addr,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic                bus_rd,
  output logic                bus_rdx,
  output logic                invalidate,
  output logic                bus_wb,
  output logic [ADDR_WID-1:0] bus_addr,
  input  logic                bus_done,
  input  logic                shared,
  output logic                mesi_upd,
  output logic [MESI_WID-1:0] new_mesi,
  output logic                cpu_done,
  output logic                busy,
  output logic                bus_err
);

  localparam logic [MESI_WID-1:0] M_S = MESI_WID'(SHARED);
  localparam logic [MESI_WID-1:0] M_E = MESI_WID'(EXCLUSIVE);
  localparam logic [MESI_WID-1:0] M_M = MESI_WID'(MODIFIED);

  state_e              state_q, state_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic [ADDR_WID-1:0] vaddr_q, vaddr_d;
  logic                wr_q, wr_d;
  logic                miss_q, miss_d;
  logic                wbp_q, wbp_d;
  logic [MESI_WID-1:0] nm_d;
  logic                tmo_fire;
  logic                expire;

  logic                bus_req_q, bus_rd_q, bus_rdx_q, inv_q, bus_wb_q;
  logic [ADDR_WID-1:0] bus_addr_q;
  logic                upd_q, busy_q, err_q;
  logic [MESI_WID-1:0] new_mesi_q;

  bus_tmo_cnt #(
    .TIMEOUT (TIMEOUT),
    .TMO_WID (TMO_WID)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_d != state_q),
    .en_i     (is_wait_state(state_q)),
    .expire_o (expire)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    vaddr_d  = vaddr_q;
    wr_d     = wr_q;
    miss_d   = miss_q;
    wbp_d    = wbp_q;
    nm_d     = '0;
    tmo_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_rd || cpu_wr) begin
          if (!hit) begin
            state_d = ARB;
            miss_d  = 1'b1;
            wbp_d   = (victim_mesi == M_M);
          end else if (cpu_wr && (blk_mesi == M_E)) begin
            state_d = UPD;
            nm_d    = M_M;
          end else if (cpu_wr && (blk_mesi != M_M)) begin
            state_d = ARB;
            miss_d  = 1'b0;
            wbp_d   = 1'b0;
          end
          // Request context is frozen here; later input changes are ignored.
          addr_d  = cpu_addr;
          vaddr_d = victim_addr;
          wr_d    = cpu_wr;
        end
      end
      ARB: begin
        if (bus_gnt) begin
          state_d = wbp_q ? WB : (miss_q ? FILL : INV);
        end
      end
      WB: begin
        if (bus_done) begin
          state_d = FILL;
        end else if (expire) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      FILL: begin
        if (bus_done) begin
          state_d = UPD;
          nm_d    = wr_q ? M_M : (shared ? M_S : M_E);
        end else if (expire) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      INV: begin
        if (bus_done) begin
          state_d = UPD;
          nm_d    = M_M;
        end else if (expire) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
      end
      UPD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so each one is valid in the
  // same cycle the FSM occupies the corresponding state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      vaddr_q    <= '0;
      wr_q       <= 1'b0;
      miss_q     <= 1'b0;
      wbp_q      <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_rd_q   <= 1'b0;
      bus_rdx_q  <= 1'b0;
      inv_q      <= 1'b0;
      bus_wb_q   <= 1'b0;
      bus_addr_q <= '0;
      upd_q      <= 1'b0;
      new_mesi_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vaddr_q    <= vaddr_d;
      wr_q       <= wr_d;
      miss_q     <= miss_d;
      wbp_q      <= wbp_d;
      bus_req_q  <= is_bus_state(state_d);
      bus_rd_q   <= (state_d == FILL) && !wr_d;
      bus_rdx_q  <= (state_d == FILL) && wr_d;
      inv_q      <= (state_d == INV);
      bus_wb_q   <= (state_d == WB);
      bus_addr_q <= (state_d == WB) ? vaddr_d :
                    ((state_d == FILL) || (state_d == INV)) ? addr_d : '0;
      upd_q      <= (state_d == UPD);
      new_mesi_q <= nm_d;
      busy_q     <= (state_d != IDLE);
      err_q      <= tmo_fire;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_rd     = bus_rd_q;
  assign bus_rdx    = bus_rdx_q;
  assign invalidate = inv_q;
  assign bus_wb     = bus_wb_q;
  assign bus_addr   = bus_addr_q;
  assign mesi_upd   = upd_q;
  assign cpu_done   = upd_q;
  assign new_mesi   = new_mesi_q;
  assign busy       = busy_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_bus_req_init_lv1_md.sv
// Self-checking bench for bus_req_init_lv1_md. Each transaction is expanded
// into a per-cycle timeline of bus-side stimulus and expected outputs, then
// played against the DUT cycle by cycle.
module tb_bus_req_init_lv1_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr, hit, bus_gnt, bus_done, shared;
  logic [31:0] cpu_addr, victim_addr, bus_addr;
  logic [1:0]  blk_mesi, victim_mesi, new_mesi;
  logic        bus_req, bus_rd, bus_rdx, invalidate, bus_wb;
  logic        mesi_upd, cpu_done, busy, bus_err;

  always #5 clk = ~clk;

  bus_req_init_lv1_md #(
    .ADDR_WID (32),
    .MESI_WID (2),
    .TIMEOUT  (8),
    .TMO_WID  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .hit         (hit),
    .blk_mesi    (blk_mesi),
    .victim_mesi (victim_mesi),
    .victim_addr (victim_addr),
    .bus_req     (bus_req),
    .bus_gnt     (bus_gnt),
    .bus_rd      (bus_rd),
    .bus_rdx     (bus_rdx),
    .invalidate  (invalidate),
    .bus_wb      (bus_wb),
    .bus_addr    (bus_addr),
    .bus_done    (bus_done),
    .shared      (shared),
    .mesi_upd    (mesi_upd),
    .new_mesi    (new_mesi),
    .cpu_done    (cpu_done),
    .busy        (busy),
    .bus_err     (bus_err)
  );

  // ctl bits: req rd rdx inv wb upd cdone busy err
  localparam logic [8:0] C_IDLE = 9'h000;
  localparam logic [8:0] C_ARB  = 9'h102;
  localparam logic [8:0] C_WB   = 9'h112;
  localparam logic [8:0] C_RD   = 9'h182;
  localparam logic [8:0] C_RDX  = 9'h142;
  localparam logic [8:0] C_INV  = 9'h122;
  localparam logic [8:0] C_UPD  = 9'h00E;
  localparam logic [8:0] C_ERR  = 9'h001;

  typedef struct {
    logic        rd, wr, gnt, done, shr;
    logic [8:0]  ctl;
    logic [31:0] addr;
    logic [1:0]  nm;
  } step_t;

  step_t       q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] t_addr, t_vaddr;
  logic        t_hit;
  logic [1:0]  t_blk, t_vm;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic add(input logic rd, input logic wr, input logic gnt, input logic done,
                     input logic shr, input logic [8:0] ctl, input logic [31:0] a,
                     input logic [1:0] nm);
    step_t s;
    s.rd = rd; s.wr = wr; s.gnt = gnt; s.done = done; s.shr = shr;
    s.ctl = ctl; s.addr = a; s.nm = nm;
    q.push_back(s);
  endtask

  // Timeline model. g: idle ARB cycles before grant; lw/lf: cycle on which
  // bus_done arrives in the writeback / fill-or-invalidate phase.
  task automatic build(input logic rd, input logic wr, input logic h, input logic [1:0] blk,
                       input logic [1:0] vm, input logic [31:0] a, input logic [31:0] va,
                       input int g, input int lw, input int lf, input logic shr,
                       input logic tmo);
    logic miss;
    logic [1:0] nm;
    q.delete();
    t_addr = a; t_vaddr = va; t_hit = h; t_blk = blk; t_vm = vm;
    miss = !h;
    add(rd, wr, 1'b0, rb(), rb(), C_IDLE, 32'h0, 2'd0);
    if (!miss && (!wr || blk == 2'd3)) begin
      add(1'b0, 1'b0, rb(), rb(), rb(), C_IDLE, 32'h0, 2'd0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'h0, 2'd0);
      return;
    end
    if (!miss && blk == 2'd2) begin
      add(1'b0, 1'b0, rb(), rb(), rb(), C_UPD, 32'h0, 2'd3);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'h0, 2'd0);
      return;
    end
    for (int i = 0; i <= g; i++)
      add(1'b0, 1'b0, (i == g), rb(), rb(), C_ARB, 32'h0, 2'd0);
    if (miss && vm == 2'd3)
      for (int i = 1; i <= lw; i++)
        add(1'b0, 1'b0, rb(), (i == lw), rb(), C_WB, va, 2'd0);
    if (tmo && miss) begin
      for (int i = 0; i < 8; i++)
        add(1'b0, 1'b0, rb(), 1'b0, rb(), wr ? C_RDX : C_RD, a, 2'd0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_ERR, 32'h0, 2'd0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'h0, 2'd0);
      return;
    end
    for (int i = 1; i <= lf; i++)
      add(1'b0, 1'b0, rb(), (i == lf), (i == lf) ? shr : rb(),
          miss ? (wr ? C_RDX : C_RD) : C_INV, a, 2'd0);
    nm = (!miss || wr) ? 2'd3 : (shr ? 2'd1 : 2'd2);
    add(1'b0, 1'b0, rb(), rb(), rb(), C_UPD, 32'h0, nm);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'h0, 2'd0);
  endtask

  task automatic check_idle(input string tag);
    n_chk++;
    assert ({bus_req, bus_rd, bus_rdx, invalidate, bus_wb, mesi_upd, cpu_done, busy, bus_err,
             bus_addr, new_mesi} === 43'h0)
    else begin
      n_fail++;
      $error("FAIL %s: got ctl=%h addr=%h nm=%0d, expected all zero", tag,
             {bus_req, bus_rd, bus_rdx, invalidate, bus_wb, mesi_upd, cpu_done, busy, bus_err},
             bus_addr, new_mesi);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic play(input string tag, input int upto);
    logic [8:0] obs;
    for (int i = 0; i < q.size() && i < upto; i++) begin
      cpu_rd = q[i].rd; cpu_wr = q[i].wr;
      if (i == 0) begin
        cpu_addr = t_addr; victim_addr = t_vaddr; hit = t_hit;
        blk_mesi = t_blk; victim_mesi = t_vm;
      end else begin
        cpu_addr = $urandom; victim_addr = $urandom; hit = rb();
        blk_mesi = 2'($urandom); victim_mesi = 2'($urandom);
      end
      bus_gnt = q[i].gnt; bus_done = q[i].done; shared = q[i].shr;
      @(negedge clk);
      obs = {bus_req, bus_rd, bus_rdx, invalidate, bus_wb, mesi_upd, cpu_done, busy, bus_err};
      n_chk++;
      assert (obs === q[i].ctl)
      else begin
        n_fail++;
        $error("FAIL %s ctl step %0d: got %h expected %h", tag, i, obs, q[i].ctl);
      end
      n_chk++;
      assert ({bus_addr, new_mesi} === {q[i].addr, q[i].nm})
      else begin
        n_fail++;
        $error("FAIL %s addr/mesi step %0d: got %h/%0d expected %h/%0d", tag, i,
               bus_addr, new_mesi, q[i].addr, q[i].nm);
      end
      n_chk++;
      assert ($countones({bus_rd, bus_rdx, invalidate, bus_wb}) <= 1)
      else begin
        n_fail++;
        $error("FAIL %s exclusive step %0d: got %b expected at most one", tag, i,
               {bus_rd, bus_rdx, invalidate, bus_wb});
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; hit = 1'b0; bus_gnt = 1'b0; bus_done = 1'b0; shared = 1'b0;
    cpu_addr = '0; victim_addr = '0; blk_mesi = '0; victim_mesi = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    build(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0000_1A40, 32'h0000_0000, 2, 1, 3, 1'b0, 1'b0);
    play("rd_miss_E", 1000);
    build(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 32'h0000_1A40, 32'h0000_2C00, 1, 3, 2, 1'b0, 1'b0);
    play("wr_miss_wb", 1000);
    build(1'b0, 1'b1, 1'b1, 2'd1, 2'd0, 32'h0000_3300, 32'h0000_4400, 0, 1, 2, 1'b0, 1'b0);
    play("wr_hit_S", 1000);
    build(1'b0, 1'b1, 1'b1, 2'd2, 2'd3, 32'h0000_3340, 32'h0000_4400, 0, 1, 1, 1'b0, 1'b0);
    play("wr_hit_E", 1000);
    build(1'b1, 1'b0, 1'b1, 2'd1, 2'd3, 32'h0000_5500, 32'h0000_6600, 0, 1, 1, 1'b0, 1'b0);
    play("rd_hit", 1000);
    build(1'b0, 1'b1, 1'b1, 2'd3, 2'd3, 32'h0000_5540, 32'h0000_6600, 0, 1, 1, 1'b0, 1'b0);
    play("wr_hit_M", 1000);
    build(1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 32'h0000_7700, 32'h0000_8800, 0, 1, 2, 1'b1, 1'b0);
    play("rd_miss_S", 1000);
    build(1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 32'h0000_7740, 32'h0000_8800, 0, 1, 1, 1'b0, 1'b0);
    play("rdwr_miss_min", 1000);
    build(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0000_9900, 32'h0000_AA00, 1, 1, 1, 1'b0, 1'b1);
    play("timeout", 1000);
    build(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0000_9940, 32'h0000_AA00, 0, 1, 8, 1'b1, 1'b0);
    play("done_at_limit", 1000);

    // Reset while the writeback is in progress.
    build(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 32'h0000_BB00, 32'h0000_CC00, 0, 5, 2, 1'b0, 1'b0);
    play("pre_rst_wb", 4);
    cpu_rd = 1'b0; cpu_wr = 1'b0; bus_gnt = 1'b0; bus_done = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_in_wb");
    @(posedge clk); #1;
    build(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 32'h0000_1A40, 32'h0000_0000, 1, 1, 2, 1'b0, 1'b0);
    play("after_rst", 1000);

    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      rd = rb(); wr = rb();
      if (!rd && !wr) rd = 1'b1;
      build(rd, wr, rb(), 2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom,
            $urandom_range(0, 4), $urandom_range(1, 8), $urandom_range(1, 8), rb(),
            ($urandom_range(0, 7) == 0));
      play("random", 1000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
